// File: rtl/reg_file_bank.sv
// MIPS general-purpose register storage: 31 writable flops plus a hardwired $zero,
// one decoded write-back port, and all 32 registers presented in parallel to the read muxes.
module reg_file_bank #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      SIZE    = 5,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [WIDTH-1:0] GP_INIT = 32'h1000_8000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [SIZE-1:0]  write_reg,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] reg_0,
  output logic [WIDTH-1:0] reg_1,
  output logic [WIDTH-1:0] reg_2,
  output logic [WIDTH-1:0] reg_3,
  output logic [WIDTH-1:0] reg_4,
  output logic [WIDTH-1:0] reg_5,
  output logic [WIDTH-1:0] reg_6,
  output logic [WIDTH-1:0] reg_7,
  output logic [WIDTH-1:0] reg_8,
  output logic [WIDTH-1:0] reg_9,
  output logic [WIDTH-1:0] reg_10,
  output logic [WIDTH-1:0] reg_11,
  output logic [WIDTH-1:0] reg_12,
  output logic [WIDTH-1:0] reg_13,
  output logic [WIDTH-1:0] reg_14,
  output logic [WIDTH-1:0] reg_15,
  output logic [WIDTH-1:0] reg_16,
  output logic [WIDTH-1:0] reg_17,
  output logic [WIDTH-1:0] reg_18,
  output logic [WIDTH-1:0] reg_19,
  output logic [WIDTH-1:0] reg_20,
  output logic [WIDTH-1:0] reg_21,
  output logic [WIDTH-1:0] reg_22,
  output logic [WIDTH-1:0] reg_23,
  output logic [WIDTH-1:0] reg_24,
  output logic [WIDTH-1:0] reg_25,
  output logic [WIDTH-1:0] reg_26,
  output logic [WIDTH-1:0] reg_27,
  output logic [WIDTH-1:0] reg_28,
  output logic [WIDTH-1:0] reg_29,
  output logic [WIDTH-1:0] reg_30,
  output logic [WIDTH-1:0] reg_31
);

  localparam int unsigned NREGS = 1 << SIZE;

  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] regs_q [NREGS];

  // One-hot enable; a disabled port yields all-zero enables regardless of write_reg.
  always_comb begin
    wr_en = '0;
    if (reg_write == 1'b1) begin
      wr_en = NREGS'(1) << write_reg;
    end
  end

  // Slot 0 is $zero: a constant, so writes to address 0 simply have no destination.
  assign regs_q[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      localparam logic [WIDTH-1:0] RST_VAL = (gi == 28) ? GP_INIT :
                                             (gi == 29) ? SP_INIT : '0;
      logic [WIDTH-1:0] val_q;
      logic [WIDTH-1:0] val_d;

      always_comb begin
        val_d = val_q;
        if (wr_en[gi]) begin
          val_d = write_data;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          val_q <= RST_VAL;
        end else begin
          val_q <= val_d;
        end
      end

      assign regs_q[gi] = val_q;
    end
  endgenerate

  assign reg_0  = regs_q[0];
  assign reg_1  = regs_q[1];
  assign reg_2  = regs_q[2];
  assign reg_3  = regs_q[3];
  assign reg_4  = regs_q[4];
  assign reg_5  = regs_q[5];
  assign reg_6  = regs_q[6];
  assign reg_7  = regs_q[7];
  assign reg_8  = regs_q[8];
  assign reg_9  = regs_q[9];
  assign reg_10 = regs_q[10];
  assign reg_11 = regs_q[11];
  assign reg_12 = regs_q[12];
  assign reg_13 = regs_q[13];
  assign reg_14 = regs_q[14];
  assign reg_15 = regs_q[15];
  assign reg_16 = regs_q[16];
  assign reg_17 = regs_q[17];
  assign reg_18 = regs_q[18];
  assign reg_19 = regs_q[19];
  assign reg_20 = regs_q[20];
  assign reg_21 = regs_q[21];
  assign reg_22 = regs_q[22];
  assign reg_23 = regs_q[23];
  assign reg_24 = regs_q[24];
  assign reg_25 = regs_q[25];
  assign reg_26 = regs_q[26];
  assign reg_27 = regs_q[27];
  assign reg_28 = regs_q[28];
  assign reg_29 = regs_q[29];
  assign reg_30 = regs_q[30];
  assign reg_31 = regs_q[31];

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank: table of single-edge writes plus hand sequences for
// async reset, walk, back-to-back writes and the no-bypass read.
module tb_reg_file_bank;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] rv [32];
  logic [31:0] exp_q [32];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [8];

  reg_file_bank dut (
    .clk(clk), .reset(reset), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .reg_0(rv[0]),   .reg_1(rv[1]),   .reg_2(rv[2]),   .reg_3(rv[3]),
    .reg_4(rv[4]),   .reg_5(rv[5]),   .reg_6(rv[6]),   .reg_7(rv[7]),
    .reg_8(rv[8]),   .reg_9(rv[9]),   .reg_10(rv[10]), .reg_11(rv[11]),
    .reg_12(rv[12]), .reg_13(rv[13]), .reg_14(rv[14]), .reg_15(rv[15]),
    .reg_16(rv[16]), .reg_17(rv[17]), .reg_18(rv[18]), .reg_19(rv[19]),
    .reg_20(rv[20]), .reg_21(rv[21]), .reg_22(rv[22]), .reg_23(rv[23]),
    .reg_24(rv[24]), .reg_25(rv[25]), .reg_26(rv[26]), .reg_27(rv[27]),
    .reg_28(rv[28]), .reg_29(rv[29]), .reg_30(rv[30]), .reg_31(rv[31])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_reset_exp();
    for (int k = 0; k < 32; k++) exp_q[k] = 32'h0;
    exp_q[28] = 32'h1000_8000;
    exp_q[29] = 32'h7FFF_EFFC;
  endtask

  task automatic check_all(input string tag);
    int bad = 0;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (rv[k] !== exp_q[k]) begin
        n_fail++;
        bad++;
        $display("FAIL %s reg_%0d actual=%08h required=%08h", tag, k, rv[k], exp_q[k]);
      end
    end
    $display("%-12s t=%0t checked 32 regs, %0d wrong", tag, $time, bad);
  endtask

  task automatic check_one(input string tag, input int k, input logic [31:0] req);
    n_checks++;
    if (rv[k] !== req) begin
      n_fail++;
      $display("FAIL %s reg_%0d actual=%08h required=%08h", tag, k, rv[k], req);
    end else begin
      $display("%-12s t=%0t reg_%0d=%08h ok", tag, $time, k, rv[k]);
    end
  endtask

  // Drive between edges, let one rising edge pass, sample 1 time unit later.
  task automatic do_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write  = we;
    write_reg  = a;
    write_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"basic_w8",  1'b1, 5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{"zero_w",    1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{"gate_r9",   1'b0, 5'd9,  32'h1234_5678, 32'h0000_0000};
    vecs[3] = '{"gp_write",  1'b1, 5'd28, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[4] = '{"gp_gated",  1'b0, 5'd28, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[5] = '{"w31",       1'b1, 5'd31, 32'h8000_0001, 32'h8000_0001};
    vecs[6] = '{"w1",        1'b1, 5'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{"zero_w2",   1'b1, 5'd0,  32'h1234_5678, 32'h0000_0000};

    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'h0;

    // Asynchronous reset between edges, checked before any rising edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    set_reset_exp();
    check_all("reset_async");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].we, vecs[i].addr, vecs[i].data);
      exp_q[vecs[i].addr] = vecs[i].exp_val;
      check_all(vecs[i].name);
    end

    // Disabled port with unknown address must not disturb anything.
    @(negedge clk);
    reg_write  = 1'b0;
    write_reg  = 5'bxxxxx;
    write_data = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    check_all("gate_addr_x");

    // Back-to-back to $sp, with in-cycle read showing the old value (no bypass).
    do_write(1'b1, 5'd29, 32'h0000_000A);
    check_one("b2b_edge1", 29, 32'h0000_000A);
    @(negedge clk);
    write_data = 32'h0000_000B;
    #1;
    check_one("no_bypass", 29, 32'h0000_000A);
    @(posedge clk);
    #1;
    check_one("b2b_edge2", 29, 32'h0000_000B);

    // Walk k+1 into every address, then reset mid-cycle.
    for (int k = 1; k < 32; k++) begin
      do_write(1'b1, 5'(k), 32'(k + 1));
    end
    for (int k = 0; k < 32; k++) exp_q[k] = (k == 0) ? 32'h0 : 32'(k + 1);
    check_all("walk");
    #2;
    reset = 1'b0;
    #1;
    set_reset_exp();
    check_all("walk_reset");

    // Reset held across an edge with a pending write: the write is discarded.
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    check_all("reset_wr_drop");
    // First write after release lands at the next rising edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_one("rel_pre_edge", 5, 32'h0000_0000);
    @(posedge clk);
    #1;
    exp_q[5] = 32'h0BAD_F00D;
    check_all("rel_first_wr");

    @(negedge clk);
    reg_write = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
